// File: rtl/syn_counter_ctrl_if.sv
// -----------------------------------------------------------------------------
// syn_counter_ctrl_if
// Command / status bundle between a control master and the counter sequencer.
//   master modport : drives cmd_valid, cmd_up, cmd_load, cmd_limit, cmd_repeat,
//                    hold, abort; observes cmd_ready, Q, busy, up, done.
//   slave modport  : the opposite view, used by syn_counter_ctrl.
// -----------------------------------------------------------------------------
interface syn_counter_ctrl_if #(
    parameter int BITS = 4
) ();
    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_up;
    logic [BITS-1:0] cmd_load;
    logic [BITS-1:0] cmd_limit;
    logic            cmd_repeat;
    logic            hold;
    logic            abort;
    logic [BITS-1:0] Q;
    logic            busy;
    logic            up;
    logic            done;

    modport master (
        output cmd_valid, cmd_up, cmd_load, cmd_limit, cmd_repeat, hold, abort,
        input  cmd_ready, Q, busy, up, done
    );

    modport slave (
        input  cmd_valid, cmd_up, cmd_load, cmd_limit, cmd_repeat, hold, abort,
        output cmd_ready, Q, busy, up, done
    );
endinterface

// File: rtl/syn_counter_ctrl.sv
// -----------------------------------------------------------------------------
// syn_counter_ctrl
// Command-driven sequencer for a BITS-wide up/down counter. One command at a
// time is accepted through a valid/ready handshake; the counter then steps one
// count per cycle from the start value to the end value, pulses done, and
// either returns to idle or reloads and keeps running.
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : syn_counter_ctrl_if.slave
//           in  : cmd_valid, cmd_up, cmd_load, cmd_limit, cmd_repeat, hold, abort
//           out : cmd_ready (combinational), Q, busy, up, done (registered)
// -----------------------------------------------------------------------------
module syn_counter_ctrl #(
    parameter int BITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    syn_counter_ctrl_if.slave   bus
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [BITS-1:0] ONE = {{(BITS-1){1'b0}}, 1'b1};

    state_t          r_state, w_state_next;
    logic [BITS-1:0] r_q,     w_q_next;
    logic [BITS-1:0] r_load,  w_load_next;
    logic [BITS-1:0] r_limit, w_limit_next;
    logic            r_up,     w_up_next;
    logic            r_repeat, w_repeat_next;
    logic            r_done,   w_done_next;

    logic w_ready;
    logic w_accept;
    logic w_active;
    logic w_terminal;

    // Priority: reset (in the register), abort, hold, terminal, count.
    // w_active is "a RUN cycle that actually advances".
    assign w_ready    = (r_state == S_IDLE) & ~bus.abort & ~reset;
    assign w_accept   = bus.cmd_valid & w_ready;
    assign w_active   = (r_state == S_RUN) & ~bus.abort & ~bus.hold;
    assign w_terminal = w_active & (r_q == r_limit);

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_q      <= '0;
            r_load   <= '0;
            r_limit  <= '0;
            r_up     <= 1'b0;
            r_repeat <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_q      <= w_q_next;
            r_load   <= w_load_next;
            r_limit  <= w_limit_next;
            r_up     <= w_up_next;
            r_repeat <= w_repeat_next;
            r_done   <= w_done_next;
        end
    end

    // --------------------------------------------------------------- next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    w_state_next = S_IDLE;
                end else if (w_terminal && !r_repeat) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // ---------------------------------------------------- datapath and outputs
    always_comb begin
        w_q_next      = r_q;
        w_load_next   = r_load;
        w_limit_next  = r_limit;
        w_up_next     = r_up;
        w_repeat_next = r_repeat;
        w_done_next   = w_terminal;

        if (w_accept) begin
            w_load_next   = bus.cmd_load;
            w_limit_next  = bus.cmd_limit;
            w_up_next     = bus.cmd_up;
            w_repeat_next = bus.cmd_repeat;
            w_q_next      = bus.cmd_load;
        end else if (w_terminal) begin
            // One-shot runs park on the limit; repeat runs restart from load.
            if (r_repeat) begin
                w_q_next = r_load;
            end
        end else if (w_active) begin
            // Plain modulo-2^BITS arithmetic gives the required wrap-around.
            w_q_next = r_up ? (r_q + ONE) : (r_q - ONE);
        end

        bus.cmd_ready = w_ready;
        bus.Q         = r_q;
        bus.busy      = (r_state == S_RUN);
        bus.up        = r_up;
        bus.done      = r_done;
    end

endmodule

// File: tb/tb_syn_counter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_syn_counter_ctrl
// Directed stimulus for syn_counter_ctrl (BITS=4). Each stimulus cycle pushes
// the hand-computed observable state for that cycle into a scoreboard queue;
// an independent monitor pops one entry per cycle on the falling edge and
// compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_syn_counter_ctrl;

    localparam int BITS = 4;

    logic clk;
    logic reset;

    syn_counter_ctrl_if #(.BITS(BITS)) bus ();

    syn_counter_ctrl #(.BITS(BITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        int              id;
        logic [BITS-1:0] q;
        logic            busy;
        logic            done;
        logic            ready;
        logic            up;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_id = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One stimulus cycle: drive inputs just after the rising edge and record
    // what the outputs must look like for the rest of this cycle.
    task automatic cyc(
        input logic            rst,
        input logic            v,
        input logic            u,
        input logic [BITS-1:0] ld,
        input logic [BITS-1:0] lm,
        input logic            rp,
        input logic            h,
        input logic            ab,
        input logic [BITS-1:0] eq,
        input logic            eb,
        input logic            ed,
        input logic            er,
        input logic            eu
    );
        exp_t e;
        @(posedge clk);
        #1;
        reset          = rst;
        bus.cmd_valid  = v;
        bus.cmd_up     = u;
        bus.cmd_load   = ld;
        bus.cmd_limit  = lm;
        bus.cmd_repeat = rp;
        bus.hold       = h;
        bus.abort      = ab;
        e.id    = cyc_id;
        e.q     = eq;
        e.busy  = eb;
        e.done  = ed;
        e.ready = er;
        e.up    = eu;
        sb.push_back(e);
        cyc_id++;
    endtask

    // Monitor: the DUT presents a fresh output set every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (bus.Q !== e.q || bus.busy !== e.busy || bus.done !== e.done ||
                    bus.cmd_ready !== e.ready || bus.up !== e.up) begin
                    errors++;
                    $display("FAIL cyc%0d: got Q=%0d busy=%b done=%b ready=%b up=%b, required Q=%0d busy=%b done=%b ready=%b up=%b",
                             e.id, bus.Q, bus.busy, bus.done, bus.cmd_ready, bus.up,
                             e.q, e.busy, e.done, e.ready, e.up);
                end else begin
                    $display("cyc%0d ok: Q=%0d busy=%b done=%b ready=%b up=%b",
                             e.id, bus.Q, bus.busy, bus.done, bus.cmd_ready, bus.up);
                end
            end
        end
    end

    initial begin
        int waited;
        reset          = 1'b1;
        bus.cmd_valid  = 1'b0;
        bus.cmd_up     = 1'b0;
        bus.cmd_load   = '0;
        bus.cmd_limit  = '0;
        bus.cmd_repeat = 1'b0;
        bus.hold       = 1'b0;
        bus.abort      = 1'b0;

        //    rst v  u  ld  lm rp h  ab    Q  b  d  r  up
        // power-up reset
        cyc(1, 0, 0,  0,  0, 0, 0, 0,    0, 0, 0, 0, 0);  // c0
        cyc(0, 0, 0,  0,  0, 0, 0, 0,    0, 0, 0, 1, 0);  // c1
        // one-shot up with wrap: 14,15,0,1,2 then done
        cyc(0, 1, 1, 14,  2, 0, 0, 0,    0, 0, 0, 1, 0);  // c2 accept
        cyc(0, 0, 0,  0,  0, 0, 0, 0,   14, 1, 0, 0, 1);
        cyc(0, 0, 0,  0,  0, 0, 0, 0,   15, 1, 0, 0, 1);
        cyc(0, 0, 0,  0,  0, 0, 0, 0,    0, 1, 0, 0, 1);
        cyc(0, 0, 0,  0,  0, 0, 0, 0,    1, 1, 0, 0, 1);
        cyc(0, 0, 0,  0,  0, 0, 0, 0,    2, 1, 0, 0, 1);  // terminal
        cyc(0, 0, 0,  0,  0, 0, 0, 0,    2, 0, 1, 1, 1);  // done
        cyc(0, 0, 0,  0,  0, 0, 0, 0,    2, 0, 0, 1, 1);
        // reset for 2 cycles mid-run while Q=9
        cyc(0, 1, 1,  6, 12, 0, 0, 0,    2, 0, 0, 1, 1);  // c10 accept
        cyc(0, 0, 0,  0,  0, 0, 0, 0,    6, 1, 0, 0, 1);
        cyc(0, 0, 0,  0,  0, 0, 0, 0,    7, 1, 0, 0, 1);
        cyc(0, 0, 0,  0,  0, 0, 0, 0,    8, 1, 0, 0, 1);
        cyc(1, 0, 0,  0,  0, 0, 0, 0,    9, 1, 0, 0, 1);  // reset rises
        cyc(1, 0, 0,  0,  0, 0, 0, 0,    0, 0, 0, 0, 0);
        cyc(0, 0, 0,  0,  0, 0, 0, 0,    0, 0, 0, 1, 0);
        // down repeat 5->3 with 2 hold cycles at Q=4
        cyc(0, 1, 0,  5,  3, 1, 0, 0,    0, 0, 0, 1, 0);  // c17 accept
        cyc(0, 0, 0,  0,  0, 0, 0, 0,    5, 1, 0, 0, 0);
        cyc(0, 0, 0,  0,  0, 0, 1, 0,    4, 1, 0, 0, 0);
        cyc(0, 0, 0,  0,  0, 0, 1, 0,    4, 1, 0, 0, 0);
        cyc(0, 0, 0,  0,  0, 0, 0, 0,    4, 1, 0, 0, 0);
        cyc(0, 0, 0,  0,  0, 0, 0, 0,    3, 1, 0, 0, 0);  // terminal
        cyc(0, 0, 0,  0,  0, 0, 0, 0,    5, 1, 1, 0, 0);  // done, reloaded
        cyc(0, 0, 0,  0,  0, 0, 0, 0,    4, 1, 0, 0, 0);
        cyc(0, 0, 0,  0,  0, 0, 0, 0,    3, 1, 0, 0, 0);
        cyc(0, 0, 0,  0,  0, 0, 0, 0,    5, 1, 1, 0, 0);
        cyc(0, 0, 0,  0,  0, 0, 0, 1,    4, 1, 0, 0, 0);  // abort mid-run
        cyc(0, 0, 0,  0,  0, 0, 0, 0,    4, 0, 0, 1, 0);
        // abort in the terminal cycle
        cyc(0, 1, 1,  1,  3, 0, 0, 0,    4, 0, 0, 1, 0);  // c29 accept
        cyc(0, 0, 0,  0,  0, 0, 0, 0,    1, 1, 0, 0, 1);
        cyc(0, 0, 0,  0,  0, 0, 0, 0,    2, 1, 0, 0, 1);
        cyc(0, 0, 0,  0,  0, 0, 0, 1,    3, 1, 0, 0, 1);  // Q==limit + abort
        cyc(0, 0, 0,  0,  0, 0, 0, 0,    3, 0, 0, 1, 1);
        cyc(0, 0, 0,  0,  0, 0, 0, 0,    3, 0, 0, 1, 1);
        // abort in IDLE blocks acceptance
        cyc(0, 1, 0,  9,  9, 0, 0, 1,    3, 0, 0, 0, 1);
        cyc(0, 0, 0,  0,  0, 0, 0, 0,    3, 0, 0, 1, 1);
        // zero-length run, then back-to-back command in the done cycle
        cyc(0, 1, 1,  7,  7, 0, 0, 0,    3, 0, 0, 1, 1);  // c37 accept
        cyc(0, 0, 0,  0,  0, 0, 0, 0,    7, 1, 0, 0, 1);  // terminal
        cyc(0, 1, 1,  0,  1, 0, 0, 0,    7, 0, 1, 1, 1);  // done + accept
        cyc(0, 0, 0,  0,  0, 0, 0, 0,    0, 1, 0, 0, 1);
        cyc(0, 0, 0,  0,  0, 0, 0, 0,    1, 1, 0, 0, 1);
        cyc(0, 0, 0,  0,  0, 0, 0, 0,    1, 0, 1, 1, 1);
        // handshake: valid held through a run with different values
        cyc(0, 1, 0,  2,  0, 0, 0, 0,    1, 0, 0, 1, 1);  // c43 accept
        cyc(0, 1, 1, 10, 12, 0, 0, 0,    2, 1, 0, 0, 0);
        cyc(0, 1, 1, 10, 12, 0, 0, 0,    1, 1, 0, 0, 0);
        cyc(0, 1, 1, 10, 12, 0, 0, 0,    0, 1, 0, 0, 0);  // terminal
        cyc(0, 1, 1, 10, 12, 0, 0, 0,    0, 0, 1, 1, 0);  // done + accept
        cyc(0, 0, 0,  0,  0, 0, 0, 0,   10, 1, 0, 0, 1);
        cyc(0, 0, 0,  0,  0, 0, 0, 0,   11, 1, 0, 0, 1);
        cyc(0, 0, 0,  0,  0, 0, 0, 0,   12, 1, 0, 0, 1);
        cyc(0, 0, 0,  0,  0, 0, 0, 0,   12, 0, 1, 1, 1);
        cyc(0, 0, 0,  0,  0, 0, 0, 0,   12, 0, 0, 1, 1);

        waited = 0;
        while (sb.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
